ysyx_23060171_wbu_ctrl: RTL and testbench

- Writeback-stage sequencer between the LSU and the register files / IFU.
- Accepts one retiring instruction per valid/ready handshake and drives the single GPR write port and the single CSR write port.
- Multi-write events are serialised over consecutive cycles: trap entry writes mepc, mcause and mstatus; mret writes mstatus.
- Emits a one-cycle commit pulse carrying the next PC to the IFU.

---
 rtl/ysyx_23060171_wbu_ctrl_if.sv | 56 +++++
 rtl/ysyx_23060171_wbu_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ysyx_23060171_wbu_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060171_wbu_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060171_wbu_ctrl_if
// Bundle of every signal between the writeback sequencer and its neighbours:
//   - LSU retire handshake  : in_valid/in_ready plus the in_* instruction fields
//   - CSR file read values  : mtvec, mepc, mstatus
//   - GPR write port        : rf_we, rf_waddr, rf_wdata
//   - CSR write port        : csr_we, csr_waddr, csr_wdata
//   - IFU commit            : commit_valid, commit_pc, next_pc
// slave  : the sequencer itself
// master : the surrounding pipeline (LSU, register files, IFU)
// ----------------------------------------------------------------------------
interface ysyx_23060171_wbu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_dnpc;
  logic [4:0]  in_rd;
  logic [31:0] in_wd;
  logic        in_rf_wen;
  logic [11:0] in_csr_addr;
  logic [31:0] in_cwd;
  logic        in_csr_wen;
  logic        in_irq;
  logic        in_ecall;
  logic        in_mret;

  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] next_pc;

  modport slave (
    input  in_valid, in_pc, in_dnpc, in_rd, in_wd, in_rf_wen,
           in_csr_addr, in_cwd, in_csr_wen, in_irq, in_ecall, in_mret,
           mtvec, mepc, mstatus,
    output in_ready, rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
           commit_valid, commit_pc, next_pc
  );

  modport master (
    output in_valid, in_pc, in_dnpc, in_rd, in_wd, in_rf_wen,
           in_csr_addr, in_cwd, in_csr_wen, in_irq, in_ecall, in_mret,
           mtvec, mepc, mstatus,
    input  in_ready, rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
           commit_valid, commit_pc, next_pc
  );
endinterface

// File: rtl/ysyx_23060171_wbu_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_23060171_wbu_ctrl
// Writeback-stage sequencer. Accepts one retiring instruction per handshake,
// drives the single GPR and single CSR write ports, serialises trap entry
// (mepc, mcause, mstatus) and mret (mstatus) over consecutive cycles, and
// pulses commit_valid with the fetch target for the IFU.
// Ports:
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   bus    : ysyx_23060171_wbu_ctrl_if.slave (handshake, CSR reads, write
//            ports, commit)
//
// state         | meaning
// --------------+--------------------------------------------------------
// S_IDLE        | nothing held, ready for a new instruction
// S_WB          | normal instruction retiring: GPR/CSR write + commit
// S_TRAP_EPC    | trap entry step 1: mepc <- pc
// S_TRAP_CAUSE  | trap entry step 2: mcause <- irq/ecall code
// S_TRAP_STATUS | trap entry step 3: mstatus update, commit to mtvec
// S_MRET_STATUS | mret: mstatus restore, commit to mepc
// ----------------------------------------------------------------------------
module ysyx_23060171_wbu_ctrl #(
  parameter logic [31:0] MCAUSE_IRQ   = 32'h8000_0007,
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input logic                        clock,
  input logic                        resetn,
  ysyx_23060171_wbu_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_TRAP_EPC,
    S_TRAP_CAUSE,
    S_TRAP_STATUS,
    S_MRET_STATUS
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  state_t      r_state;
  state_t      w_next;
  state_t      w_cls;

  logic [31:0] r_pc;
  logic [31:0] r_dnpc;
  logic [4:0]  r_rd;
  logic [31:0] r_wd;
  logic        r_rf_wen;
  logic [11:0] r_csr_addr;
  logic [31:0] r_cwd;
  logic        r_csr_wen;
  logic        r_irq;

  logic        w_ready;
  logic        w_xfer;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_csr_we;
  logic [11:0] w_csr_waddr;
  logic [31:0] w_csr_wdata;
  logic        w_commit;
  logic [31:0] w_commit_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_ms_trap;
  logic [31:0] w_ms_mret;

  assign w_ready = (r_state == S_IDLE) || (r_state == S_WB);
  assign w_xfer  = bus.in_valid && w_ready;

  // Classification priority: irq > ecall > mret > normal.
  always_comb begin
    if (bus.in_irq || bus.in_ecall) w_cls = S_TRAP_EPC;
    else if (bus.in_mret)           w_cls = S_MRET_STATUS;
    else                            w_cls = S_WB;
  end

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  always_comb begin
    w_ms_trap        = bus.mstatus;
    w_ms_trap[7]     = bus.mstatus[3];
    w_ms_trap[3]     = 1'b0;
    w_ms_trap[12:11] = 2'b11;
  end

  // mret: MIE <- MPIE, MPIE <- 1, MPP <- U.
  always_comb begin
    w_ms_mret        = bus.mstatus;
    w_ms_mret[3]     = bus.mstatus[7];
    w_ms_mret[7]     = 1'b1;
    w_ms_mret[12:11] = 2'b00;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc       <= '0;
      r_dnpc     <= '0;
      r_rd       <= '0;
      r_wd       <= '0;
      r_rf_wen   <= 1'b0;
      r_csr_addr <= '0;
      r_cwd      <= '0;
      r_csr_wen  <= 1'b0;
      r_irq      <= 1'b0;
    end else if (w_xfer) begin
      r_pc       <= bus.in_pc;
      r_dnpc     <= bus.in_dnpc;
      r_rd       <= bus.in_rd;
      r_wd       <= bus.in_wd;
      r_rf_wen   <= bus.in_rf_wen;
      r_csr_addr <= bus.in_csr_addr;
      r_cwd      <= bus.in_cwd;
      r_csr_wen  <= bus.in_csr_wen;
      r_irq      <= bus.in_irq;
    end
  end

  // Outputs default to zero so every address/data field reads 0 whenever its
  // enable is low.
  always_comb begin
    w_next      = r_state;
    w_rf_we     = 1'b0;
    w_rf_waddr  = '0;
    w_rf_wdata  = '0;
    w_csr_we    = 1'b0;
    w_csr_waddr = '0;
    w_csr_wdata = '0;
    w_commit    = 1'b0;
    w_commit_pc = '0;
    w_next_pc   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_next = w_cls;
      end
      S_WB: begin
        if (r_rf_wen && (r_rd != 5'd0)) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = r_rd;
          w_rf_wdata = r_wd;
        end
        if (r_csr_wen) begin
          w_csr_we    = 1'b1;
          w_csr_waddr = r_csr_addr;
          w_csr_wdata = r_cwd;
        end
        w_commit    = 1'b1;
        w_commit_pc = r_pc;
        w_next_pc   = r_dnpc;
        w_next      = w_xfer ? w_cls : S_IDLE;
      end
      S_TRAP_EPC: begin
        w_csr_we    = 1'b1;
        w_csr_waddr = CSR_MEPC;
        w_csr_wdata = r_pc;
        w_next      = S_TRAP_CAUSE;
      end
      S_TRAP_CAUSE: begin
        w_csr_we    = 1'b1;
        w_csr_waddr = CSR_MCAUSE;
        w_csr_wdata = r_irq ? MCAUSE_IRQ : MCAUSE_ECALL;
        w_next      = S_TRAP_STATUS;
      end
      S_TRAP_STATUS: begin
        w_csr_we    = 1'b1;
        w_csr_waddr = CSR_MSTATUS;
        w_csr_wdata = w_ms_trap;
        w_commit    = 1'b1;
        w_commit_pc = r_pc;
        w_next_pc   = bus.mtvec;
        w_next      = S_IDLE;
      end
      S_MRET_STATUS: begin
        w_csr_we    = 1'b1;
        w_csr_waddr = CSR_MSTATUS;
        w_csr_wdata = w_ms_mret;
        w_commit    = 1'b1;
        w_commit_pc = r_pc;
        w_next_pc   = bus.mepc;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.in_ready     = w_ready;
  assign bus.rf_we        = w_rf_we;
  assign bus.rf_waddr     = w_rf_waddr;
  assign bus.rf_wdata     = w_rf_wdata;
  assign bus.csr_we       = w_csr_we;
  assign bus.csr_waddr    = w_csr_waddr;
  assign bus.csr_wdata    = w_csr_wdata;
  assign bus.commit_valid = w_commit;
  assign bus.commit_pc    = w_commit_pc;
  assign bus.next_pc      = w_next_pc;

endmodule

// File: tb/tb_ysyx_23060171_wbu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060171_wbu_ctrl
// Directed vector table, hand-written corner sequences and a randomized run
// against a queue-based reference model of the writeback sequencer.
// ----------------------------------------------------------------------------
module tb_ysyx_23060171_wbu_ctrl;

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_errors;

  ysyx_23060171_wbu_ctrl_if bus();

  ysyx_23060171_wbu_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        cv;
    logic [31:0] cpc;
    logic [31:0] npc;
  } outs_t;

  // Reference model: one record per expected output cycle.
  // kind: 0 normal writeback, 1 mepc, 2 mcause, 3 mstatus+commit (trap), 4 mret
  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        rf_wen;
    logic [11:0] caddr;
    logic [31:0] cwd;
    logic        csr_wen;
    logic        irq;
  } rec_t;

  typedef struct {
    logic [31:0] pc, dnpc;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        rf_wen;
    logic [11:0] caddr;
    logic [31:0] cwd;
    logic        csr_wen, irq, ecall, mret;
    logic [31:0] mtvec, mepc, mstatus;
    int          exp_lat;
    logic        exp_rf_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_csr_we;
    logic [11:0] exp_caddr;
    logic [31:0] exp_cdata;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vecs[8];
  rec_t q[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.ready     = bus.in_ready;
    o.rf_we     = bus.rf_we;
    o.rf_waddr  = bus.rf_waddr;
    o.rf_wdata  = bus.rf_wdata;
    o.csr_we    = bus.csr_we;
    o.csr_waddr = bus.csr_waddr;
    o.csr_wdata = bus.csr_wdata;
    o.cv        = bus.commit_valid;
    o.cpc       = bus.commit_pc;
    o.npc       = bus.next_pc;
    return o;
  endfunction

  function automatic logic [31:0] ms_trap(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | ({31'd0, ms[3]} << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ms_mret(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | ({31'd0, ms[7]} << 3) | 32'h0000_0080;
  endfunction

  function automatic outs_t model_out(input bit have, input rec_t r, input bit rdy,
                                      input logic [31:0] tv, input logic [31:0] ep,
                                      input logic [31:0] ms);
    outs_t o;
    o = '0;
    o.ready = rdy;
    if (have) begin
      case (r.kind)
        3'd0: begin
          if (r.rf_wen && r.rd != 0) begin
            o.rf_we = 1'b1; o.rf_waddr = r.rd; o.rf_wdata = r.wd;
          end
          if (r.csr_wen) begin
            o.csr_we = 1'b1; o.csr_waddr = r.caddr; o.csr_wdata = r.cwd;
          end
          o.cv = 1'b1; o.cpc = r.pc; o.npc = r.dnpc;
        end
        3'd1: begin o.csr_we = 1'b1; o.csr_waddr = 12'h341; o.csr_wdata = r.pc; end
        3'd2: begin
          o.csr_we = 1'b1; o.csr_waddr = 12'h342;
          o.csr_wdata = r.irq ? 32'h8000_0007 : 32'd11;
        end
        3'd3: begin
          o.csr_we = 1'b1; o.csr_waddr = 12'h300; o.csr_wdata = ms_trap(ms);
          o.cv = 1'b1; o.cpc = r.pc; o.npc = tv;
        end
        default: begin
          o.csr_we = 1'b1; o.csr_waddr = 12'h300; o.csr_wdata = ms_mret(ms);
          o.cv = 1'b1; o.cpc = r.pc; o.npc = ep;
        end
      endcase
    end
    return o;
  endfunction

  task automatic clear_inputs();
    bus.in_valid = 0; bus.in_pc = 0; bus.in_dnpc = 0; bus.in_rd = 0; bus.in_wd = 0;
    bus.in_rf_wen = 0; bus.in_csr_addr = 0; bus.in_cwd = 0; bus.in_csr_wen = 0;
    bus.in_irq = 0; bus.in_ecall = 0; bus.in_mret = 0;
    bus.mtvec = 0; bus.mepc = 0; bus.mstatus = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.in_pc = v.pc; bus.in_dnpc = v.dnpc; bus.in_rd = v.rd; bus.in_wd = v.wd;
    bus.in_rf_wen = v.rf_wen; bus.in_csr_addr = v.caddr; bus.in_cwd = v.cwd;
    bus.in_csr_wen = v.csr_wen; bus.in_irq = v.irq; bus.in_ecall = v.ecall;
    bus.in_mret = v.mret; bus.mtvec = v.mtvec; bus.mepc = v.mepc;
    bus.mstatus = v.mstatus; bus.in_valid = 1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    outs_t o;
    int lat;
    bit found;
    v = vecs[idx];
    @(negedge clock);
    drive_vec(v);
    @(negedge clock);
    bus.in_valid = 0;
    found = 0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge clock);
      #1;
      o = sample();
      if (o.cv && !found) begin
        found = 1;
        lat = i;
        chk($sformatf("vec%0d_commit", idx),
            {o.rf_we, o.rf_waddr, o.rf_wdata, o.csr_we, o.csr_waddr, o.csr_wdata, o.cpc, o.npc},
            {v.exp_rf_we, v.exp_waddr, v.exp_wdata, v.exp_csr_we, v.exp_caddr,
             v.exp_cdata, v.pc, v.exp_npc});
      end
    end
    chk($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
  endtask

  initial begin
    outs_t o;
    outs_t e;
    rec_t  r;
    bit    rdy;
    bit    have;
    logic [31:0] pcs[4];

    n_checks = 0;
    n_errors = 0;
    resetn   = 0;
    clear_inputs();

    //          pc            dnpc          rd  wd            rfw caddr  cwd           cw irq ec mr mtvec         mepc          mstatus       lat rfwe wa  wdata        cwe caddr  cdata         npc
    vecs[0] = '{32'h8000_0000, 32'h8000_0004, 5, 32'h1234,     1, 12'h0,  32'h0,        0, 0,  0, 0, 32'h0,        32'h0,        32'h0,        1,  1,   5,  32'h1234,    0,  12'h0, 32'h0,        32'h8000_0004};
    vecs[1] = '{32'h8000_0004, 32'h8000_0008, 0, 32'h5555,     1, 12'h0,  32'h0,        0, 0,  0, 0, 32'h0,        32'h0,        32'h0,        1,  0,   0,  32'h0,       0,  12'h0, 32'h0,        32'h8000_0008};
    vecs[2] = '{32'h8000_0008, 32'h8000_000c, 3, 32'h7,        1, 12'h305,32'hdead_beef,1, 0,  0, 0, 32'h0,        32'h0,        32'h0,        1,  1,   3,  32'h7,       1,  12'h305,32'hdead_beef, 32'h8000_000c};
    vecs[3] = '{32'h8000_0010, 32'h8000_0014, 0, 32'h0,        0, 12'h0,  32'h0,        0, 0,  1, 0, 32'h8000_0100, 32'h0,        32'h8,        3,  0,   0,  32'h0,       1,  12'h300,32'h1880,     32'h8000_0100};
    vecs[4] = '{32'h8000_0020, 32'h8000_0024, 0, 32'h0,        0, 12'h0,  32'h0,        0, 0,  0, 1, 32'h0,        32'h8000_0014, 32'h1880,     1,  0,   0,  32'h0,       1,  12'h300,32'h0088,     32'h8000_0014};
    vecs[5] = '{32'h8000_0030, 32'h8000_0034, 0, 32'h0,        0, 12'h0,  32'h0,        0, 0,  1, 1, 32'h8000_0200, 32'h8000_0014, 32'h0,        3,  0,   0,  32'h0,       1,  12'h300,32'h1800,     32'h8000_0200};
    vecs[6] = '{32'h8000_0040, 32'h8000_0044, 4, 32'h99,       1, 12'h305,32'h1,        1, 1,  0, 0, 32'h8000_0300, 32'h0,        32'h88,       3,  0,   0,  32'h0,       1,  12'h300,32'h1880,     32'h8000_0300};
    vecs[7] = '{32'h8000_0050, 32'h8000_0054, 0, 32'h0,        0, 12'h0,  32'h0,        0, 0,  0, 1, 32'h0,        32'h8000_0050, 32'hffff_fff7, 1,  0,   0,  32'h0,       1,  12'h300,32'hffff_e7ff, 32'h8000_0050};

    // Reset state: everything zero, ready high, nothing accepted while held.
    repeat (2) @(negedge clock);
    bus.in_valid = 1;
    @(negedge clock);
    #1;
    chk("reset_outputs", sample(), outs_t'({1'b1, 148'd0}));
    bus.in_valid = 0;
    resetn = 1;
    @(negedge clock);
    #1;
    chk("post_reset_idle", sample(), outs_t'({1'b1, 148'd0}));

    for (int i = 0; i < 8; i++) run_vec(i);

    // Back-to-back: four instructions, one commit per cycle in order.
    for (int k = 0; k < 4; k++) pcs[k] = 32'h8000_1000 + 32'(k * 4);
    @(negedge clock);
    clear_inputs();
    for (int k = 0; k <= 4; k++) begin
      #1;
      o = sample();
      chk($sformatf("b2b_ready%0d", k), o.ready, 1'b1);
      if (k > 0) chk($sformatf("b2b_commit%0d", k), {o.cv, o.cpc, o.npc},
                     {1'b1, pcs[k-1], pcs[k-1] + 32'd4});
      if (k < 4) begin
        bus.in_valid = 1; bus.in_pc = pcs[k]; bus.in_dnpc = pcs[k] + 32'd4;
        bus.in_rd = 5'(k + 1); bus.in_wd = 32'(k); bus.in_rf_wen = 1;
      end else bus.in_valid = 0;
      @(negedge clock);
    end
    #1;
    chk("b2b_done", bus.commit_valid, 1'b0);

    // ecall step by step: ready low and no GPR write during the trap.
    clear_inputs();
    bus.in_valid = 1; bus.in_ecall = 1; bus.in_pc = 32'h8000_0010;
    bus.in_rd = 7; bus.in_rf_wen = 1;
    bus.mtvec = 32'h8000_0100; bus.mstatus = 32'h8;
    @(negedge clock);
    bus.in_valid = 0;
    #1;
    o = sample();
    chk("ecall_epc", {o.ready, o.rf_we, o.csr_we, o.csr_waddr, o.csr_wdata, o.cv},
        {1'b0, 1'b0, 1'b1, 12'h341, 32'h8000_0010, 1'b0});
    @(negedge clock);
    #1;
    o = sample();
    chk("ecall_cause", {o.ready, o.rf_we, o.csr_we, o.csr_waddr, o.csr_wdata, o.cv},
        {1'b0, 1'b0, 1'b1, 12'h342, 32'd11, 1'b0});
    @(negedge clock);
    #1;
    o = sample();
    chk("ecall_status", {o.ready, o.rf_we, o.csr_we, o.csr_waddr, o.csr_wdata, o.cv, o.npc},
        {1'b0, 1'b0, 1'b1, 12'h300, 32'h1880, 1'b1, 32'h8000_0100});

    // irq together with ecall: interrupt cause wins.
    @(negedge clock);
    clear_inputs();
    bus.in_valid = 1; bus.in_irq = 1; bus.in_ecall = 1; bus.in_pc = 32'h8000_0060;
    @(negedge clock);
    bus.in_valid = 0;
    @(negedge clock);
    #1;
    chk("irq_ecall_cause", {bus.csr_we, bus.csr_waddr, bus.csr_wdata},
        {1'b1, 12'h342, 32'h8000_0007});
    repeat (2) @(negedge clock);

    // Reset in the middle of a trap: abandoned, never resumed.
    clear_inputs();
    bus.in_valid = 1; bus.in_ecall = 1; bus.in_pc = 32'h8000_0070;
    @(negedge clock);
    bus.in_valid = 0;
    @(negedge clock);
    #1;
    chk("rst_mid_in_cause", {bus.csr_we, bus.csr_waddr}, {1'b1, 12'h342});
    resetn = 0;
    #1;
    chk("rst_mid_outputs", sample(), outs_t'({1'b1, 148'd0}));
    @(negedge clock);
    resetn = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("rst_mid_idle%0d", k), sample(), outs_t'({1'b1, 148'd0}));
    end

    // Randomized run against the queue model; CSR read values change every cycle.
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      bus.mtvec = $urandom; bus.mepc = $urandom; bus.mstatus = $urandom;
      #1;
      have = (q.size() > 0);
      r = have ? q[0] : '0;
      rdy = !have || (q.size() == 1 && q[0].kind == 3'd0);
      e = model_out(have, r, rdy, bus.mtvec, bus.mepc, bus.mstatus);
      chk("rand_cycle", sample(), e);
      if (have) void'(q.pop_front());
      bus.in_valid = (c < 2990) && ($urandom_range(3) != 0);
      bus.in_pc = $urandom; bus.in_dnpc = $urandom; bus.in_rd = 5'($urandom);
      bus.in_wd = $urandom; bus.in_rf_wen = 1'($urandom);
      bus.in_csr_addr = 12'($urandom); bus.in_cwd = $urandom;
      bus.in_csr_wen = 1'($urandom);
      bus.in_irq = ($urandom_range(9) == 0);
      bus.in_ecall = ($urandom_range(9) == 0);
      bus.in_mret = ($urandom_range(9) == 0);
      if (bus.in_valid && rdy) begin
        r.pc = bus.in_pc; r.dnpc = bus.in_dnpc; r.rd = bus.in_rd; r.wd = bus.in_wd;
        r.rf_wen = bus.in_rf_wen; r.caddr = bus.in_csr_addr; r.cwd = bus.in_cwd;
        r.csr_wen = bus.in_csr_wen; r.irq = bus.in_irq;
        if (bus.in_irq || bus.in_ecall) begin
          r.kind = 3'd1; q.push_back(r);
          r.kind = 3'd2; q.push_back(r);
          r.kind = 3'd3; q.push_back(r);
        end else if (bus.in_mret) begin
          r.kind = 3'd4; q.push_back(r);
        end else begin
          r.kind = 3'd0; q.push_back(r);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
